ref_cache_req_arb: RTL and testbench

Two-requester round-robin front end for the pipelined inter-prediction reference cache. It accepts reference-block fetch requests from the list-0 and list-1 prediction paths and issues them one at a time into the cache's single request port, gated by the cache-idle handshake. It keeps an in-order tag FIFO of outstanding requests so that each cache output block is routed back to the requester that asked for it. Downstream back-pressure is translated into the cache's filter-idle input.

---
 rtl/ref_cache_req_arb.sv | 223 ++++++++++++++++++++++
 tb/tb_ref_cache_req_arb.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_cache_req_arb.sv
// ref_cache_req_arb
// Two-requester round-robin front end for the inter-prediction reference
// cache. Issues list-0 / list-1 fetch requests one at a time into the cache
// request port, remembers who asked in an in-order tag FIFO, and routes each
// cache output block back to its requester.
//
// Optional feature macro: CACHE_ARB_PERF_CNT_EN adds saturating grant/stall
// performance counters (grant0_cnt_out, grant1_cnt_out, stall_cnt_out).
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   reqN_valid_in/data_in       request from list N (held until granted)
//   reqN_ready_out              list N granted this cycle (combinational)
//   cache_req_valid_out/data    registered request to the cache
//   cache_idle_in               cache can take a new request
//   cache_resp_valid_in         cache output block valid
//   cache_resp_ready_out        cache filter-idle (consumer of head tag ready)
//   respN_valid_out/ready_in    routed response handshake
//   outstanding_out             tag FIFO occupancy
//   arb_idle_out                nothing outstanding and arbiter in ARB
//   err_out                     sticky: response seen with empty tag FIFO
module ref_cache_req_arb #(
  parameter  int REQ_WIDTH = 64,
  parameter  int MAX_OUT   = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int PTR_W     = $clog2(MAX_OUT),
  localparam int OCC_W     = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid_in,
  input  logic [REQ_WIDTH-1:0] req0_data_in,
  output logic                 req0_ready_out,
  input  logic                 req1_valid_in,
  input  logic [REQ_WIDTH-1:0] req1_data_in,
  output logic                 req1_ready_out,
  output logic                 cache_req_valid_out,
  output logic [REQ_WIDTH-1:0] cache_req_data_out,
  input  logic                 cache_idle_in,
  input  logic                 cache_resp_valid_in,
  output logic                 cache_resp_ready_out,
  output logic                 resp0_valid_out,
  output logic                 resp1_valid_out,
  input  logic                 resp0_ready_in,
  input  logic                 resp1_ready_in,
  output logic [OCC_W-1:0]     outstanding_out,
  output logic                 arb_idle_out,
  output logic                 err_out
`ifdef CACHE_ARB_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] grant0_cnt_out,
  output logic [CNT_WIDTH-1:0] grant1_cnt_out,
  output logic [CNT_WIDTH-1:0] stall_cnt_out
`endif
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;     // side of the most recent grant
  logic [REQ_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic [MAX_OUT-1:0]     tag_q, tag_d;       // one requester bit per slot
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [OCC_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;

  logic fifo_empty_s;
  logic fifo_full_s;
  logic head_tag_s;
  logic any_req_s;
  logic grant_s;
  logic grant_side_s;
  logic pop_s;

  // Request arbitration and response routing decode
  always_comb begin
    fifo_empty_s = (cnt_q == {OCC_W{1'b0}});
    fifo_full_s  = (cnt_q == OCC_W'(MAX_OUT));
    head_tag_s   = tag_q[rd_q];
    any_req_s    = req0_valid_in | req1_valid_in;
    // A pop in the same cycle does not free a slot for this cycle's grant.
    grant_s      = (state_q == ST_ARB) & any_req_s & cache_idle_in & ~fifo_full_s;
    // On a tie the side that did not win last time goes next.
    if (req0_valid_in && req1_valid_in) begin
      grant_side_s = ~last_q;
    end else begin
      grant_side_s = req1_valid_in;
    end
    if (fifo_empty_s) begin
      cache_resp_ready_out = 1'b0;
    end else begin
      cache_resp_ready_out = head_tag_s ? resp1_ready_in : resp0_ready_in;
    end
    pop_s = cache_resp_valid_in & cache_resp_ready_out;
  end

  assign req0_ready_out      = grant_s & ~grant_side_s;
  assign req1_ready_out      = grant_s &  grant_side_s;
  assign resp0_valid_out     = cache_resp_valid_in & ~fifo_empty_s & ~head_tag_s;
  assign resp1_valid_out     = cache_resp_valid_in & ~fifo_empty_s &  head_tag_s;
  assign cache_req_valid_out = valid_q;
  assign cache_req_data_out  = data_q;
  assign outstanding_out     = cnt_q;
  assign arb_idle_out        = (state_q == ST_ARB) & fifo_empty_s;
  assign err_out             = err_q;

  // Arbiter FSM next state; HOLD covers the cache's one-cycle idle lag
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    valid_d = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (grant_s) begin
          state_d = ST_HOLD;
          last_d  = grant_side_s;
          data_d  = grant_side_s ? req1_data_in : req0_data_in;
          valid_d = 1'b1;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_HOLD: begin
        state_d = ST_ARB;
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // Tag FIFO next state and sticky error flag
  always_comb begin
    tag_d = tag_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (grant_s) begin
      tag_d[wr_q] = grant_side_s;
      wr_d        = wr_q + PTR_W'(1);
    end else begin
      wr_d = wr_q;
    end
    if (pop_s) begin
      rd_d = rd_q + PTR_W'(1);
    end else begin
      rd_d = rd_q;
    end
    case ({grant_s, pop_s})
      2'b10:   cnt_d = cnt_q + OCC_W'(1);
      2'b01:   cnt_d = cnt_q - OCC_W'(1);
      default: cnt_d = cnt_q;
    endcase
    err_d = err_q | (cache_resp_valid_in & fifo_empty_s);
  end

  // State, request and tag FIFO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ARB;
      last_q  <= 1'b1;
      data_q  <= {REQ_WIDTH{1'b0}};
      valid_q <= 1'b0;
      tag_q   <= {MAX_OUT{1'b0}};
      wr_q    <= {PTR_W{1'b0}};
      rd_q    <= {PTR_W{1'b0}};
      cnt_q   <= {OCC_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef CACHE_ARB_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] g0_cnt_q, g1_cnt_q, st_cnt_q;
  logic                 stall_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    if (inc && (v != {CNT_WIDTH{1'b1}})) begin
      return v + CNT_WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // Stall: a request is waiting in ARB but cannot be issued
  always_comb begin
    stall_s = (state_q == ST_ARB) & any_req_s & ~grant_s;
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g0_cnt_q <= {CNT_WIDTH{1'b0}};
      g1_cnt_q <= {CNT_WIDTH{1'b0}};
      st_cnt_q <= {CNT_WIDTH{1'b0}};
    end else begin
      g0_cnt_q <= sat_inc(g0_cnt_q, req0_ready_out);
      g1_cnt_q <= sat_inc(g1_cnt_q, req1_ready_out);
      st_cnt_q <= sat_inc(st_cnt_q, stall_s);
    end
  end

  assign grant0_cnt_out = g0_cnt_q;
  assign grant1_cnt_out = g1_cnt_q;
  assign stall_cnt_out  = st_cnt_q;
`endif

endmodule

// File: tb/tb_ref_cache_req_arb.sv
// Self-checking bench for ref_cache_req_arb: directed scenarios plus
// randomized traffic compared against a queue-based behavioural model.
module tb_ref_cache_req_arb;
  localparam int RW   = 64;
  localparam int MO   = 4;
  localparam int CW   = 16;
  localparam int OW   = $clog2(MO) + 1;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid_in, req1_valid_in;
  logic [RW-1:0] req0_data_in, req1_data_in;
  logic          req0_ready_out, req1_ready_out;
  logic          cache_req_valid_out;
  logic [RW-1:0] cache_req_data_out;
  logic          cache_idle_in, cache_resp_valid_in, cache_resp_ready_out;
  logic          resp0_valid_out, resp1_valid_out;
  logic          resp0_ready_in, resp1_ready_in;
  logic [OW-1:0] outstanding_out;
  logic          arb_idle_out, err_out;
`ifdef CACHE_ARB_PERF_CNT_EN
  logic [CW-1:0] grant0_cnt_out, grant1_cnt_out, stall_cnt_out;
`endif

  always #5 clk = ~clk;

  ref_cache_req_arb #(.REQ_WIDTH(RW), .MAX_OUT(MO), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid_in(req0_valid_in), .req0_data_in(req0_data_in), .req0_ready_out(req0_ready_out),
    .req1_valid_in(req1_valid_in), .req1_data_in(req1_data_in), .req1_ready_out(req1_ready_out),
    .cache_req_valid_out(cache_req_valid_out), .cache_req_data_out(cache_req_data_out),
    .cache_idle_in(cache_idle_in), .cache_resp_valid_in(cache_resp_valid_in),
    .cache_resp_ready_out(cache_resp_ready_out),
    .resp0_valid_out(resp0_valid_out), .resp1_valid_out(resp1_valid_out),
    .resp0_ready_in(resp0_ready_in), .resp1_ready_in(resp1_ready_in),
    .outstanding_out(outstanding_out), .arb_idle_out(arb_idle_out), .err_out(err_out)
`ifdef CACHE_ARB_PERF_CNT_EN
    , .grant0_cnt_out(grant0_cnt_out), .grant1_cnt_out(grant1_cnt_out),
    .stall_cnt_out(stall_cnt_out)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Behavioural model: outstanding tags as a queue, "issuing" flag for the
  // one cycle after a grant, and the side that most recently won.
  int          mq[$];
  bit          m_issuing;
  int          m_last;
  bit          m_err;
  logic [63:0] m_data;
  int          m_g0, m_g1, m_st;
  bit          e_grant, e_pop, e_stall, e_bad_resp;
  int          e_side;

  function automatic void model_reset();
    mq.delete();
    m_issuing = 1'b0;
    m_last    = 1;
    m_err     = 1'b0;
    m_data    = 64'd0;
    m_g0 = 0; m_g1 = 0; m_st = 0;
  endfunction

  // Drive one cycle of inputs on the falling edge, then compare every output
  task automatic drive_and_check(input bit v0, input logic [63:0] d0, input bit v1,
                                 input logic [63:0] d1, input bit idle, input bit rv,
                                 input bit r0, input bit r1);
    int  occ;
    int  head;
    bit  crr;
    @(negedge clk);
    req0_valid_in = v0; req0_data_in = d0;
    req1_valid_in = v1; req1_data_in = d1;
    cache_idle_in = idle; cache_resp_valid_in = rv;
    resp0_ready_in = r0; resp1_ready_in = r1;
    #1;
    occ        = mq.size();
    head       = (occ > 0) ? mq[0] : 0;
    e_grant    = !m_issuing && (v0 || v1) && idle && (occ < MO);
    e_side     = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
    crr        = (occ > 0) ? ((head == 0) ? r0 : r1) : 1'b0;
    e_pop      = rv && crr;
    e_bad_resp = rv && (occ == 0);
    e_stall    = !m_issuing && (v0 || v1) && !e_grant;
    check_eq("req0_ready", req0_ready_out, e_grant && e_side == 0);
    check_eq("req1_ready", req1_ready_out, e_grant && e_side == 1);
    check_eq("cache_valid", cache_req_valid_out, m_issuing);
    check_eq("cache_data", cache_req_data_out, m_data);
    check_eq("resp0_valid", resp0_valid_out, rv && occ > 0 && head == 0);
    check_eq("resp1_valid", resp1_valid_out, rv && occ > 0 && head == 1);
    check_eq("cache_resp_ready", cache_resp_ready_out, crr);
    check_eq("outstanding", outstanding_out, occ);
    check_eq("arb_idle", arb_idle_out, !m_issuing && occ == 0);
    check_eq("err", err_out, m_err);
`ifdef CACHE_ARB_PERF_CNT_EN
    check_eq("grant0_cnt", grant0_cnt_out, m_g0);
    check_eq("grant1_cnt", grant1_cnt_out, m_g1);
    check_eq("stall_cnt", stall_cnt_out, m_st);
`endif
  endtask

  // Let the clock edge happen and advance the model accordingly
  task automatic advance();
    @(posedge clk);
    if (e_pop) void'(mq.pop_front());
    if (e_bad_resp) m_err = 1'b1;
    if (e_grant) begin
      mq.push_back(e_side);
      m_data    = (e_side == 1) ? req1_data_in : req0_data_in;
      m_last    = e_side;
      m_issuing = 1'b1;
      if (e_side == 0 && m_g0 < CMAX) m_g0++;
      if (e_side == 1 && m_g1 < CMAX) m_g1++;
    end else begin
      m_issuing = 1'b0;
    end
    if (e_stall && m_st < CMAX) m_st++;
  endtask

  task automatic step(input bit v0, input logic [63:0] d0, input bit v1, input logic [63:0] d1,
                      input bit idle, input bit rv, input bit r0, input bit r1);
    drive_and_check(v0, d0, v1, d1, idle, rv, r0, r1);
    advance();
  endtask

  // Assert reset mid-cycle and check the cleared state immediately
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    req0_valid_in = 1'b0; req1_valid_in = 1'b0; req0_data_in = '0; req1_data_in = '0;
    cache_idle_in = 1'b0; cache_resp_valid_in = 1'b0;
    resp0_ready_in = 1'b0; resp1_ready_in = 1'b0;
    #1;
    model_reset();
    check_eq("rst_outstanding", outstanding_out, 0);
    check_eq("rst_arb_idle", arb_idle_out, 1);
    check_eq("rst_err", err_out, 0);
    check_eq("rst_cache_valid", cache_req_valid_out, 0);
    check_eq("rst_cache_data", cache_req_data_out, 0);
`ifdef CACHE_ARB_PERF_CNT_EN
    check_eq("rst_g0", grant0_cnt_out, 0);
    check_eq("rst_g1", grant1_cnt_out, 0);
    check_eq("rst_stall", stall_cnt_out, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    bit          p0, p1;
    logic [63:0] pd0, pd1;
    bit          rv;
    reset = 1'b0;
    model_reset();
    do_reset();

    // Single request, response 10 cycles after the grant
    drive_and_check(1, 64'h1234, 0, 64'd0, 1, 0, 0, 0);
    check_eq("single_ready0", req0_ready_out, 1);
    advance();
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    check_eq("single_valid_c1", cache_req_valid_out, 1);
    check_eq("single_data", cache_req_data_out, 64'h1234);
    check_eq("single_occ", outstanding_out, 1);
    advance();
    for (int c = 2; c < 10; c++) step(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 1, 1, 1);
    check_eq("single_resp0", resp0_valid_out, 1);
    advance();
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    check_eq("single_occ_after", outstanding_out, 0);
    advance();

    // Contention from reset: 0,1,0,1 at 2-cycle spacing, filling the FIFO
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive_and_check(1, 64'hA0 + c, 1, 64'hB0 + c, 1, 0, 0, 0);
      check_eq("cont_ready0", req0_ready_out, (c % 4) == 0);
      check_eq("cont_ready1", req1_ready_out, (c % 4) == 2);
      advance();
    end
    // Full: both wait, then one pop, then a grant the next cycle
    drive_and_check(1, 64'hC0, 1, 64'hC1, 1, 0, 0, 0);
    check_eq("full_ready0", req0_ready_out, 0);
    check_eq("full_ready1", req1_ready_out, 0);
    check_eq("full_occ", outstanding_out, MO);
    advance();
    drive_and_check(1, 64'hC0, 1, 64'hC1, 1, 1, 1, 1);
    check_eq("full_pop_resp0", resp0_valid_out, 1);
    check_eq("full_pop_noready", req0_ready_out | req1_ready_out, 0);
    advance();
    drive_and_check(1, 64'hC0, 1, 64'hC1, 1, 0, 0, 0);
    check_eq("full_regrant", req0_ready_out, 1);
    advance();

    // Routing with back-pressure: tags 1 then 0
    do_reset();
    step(0, 64'd0, 1, 64'h11, 1, 0, 0, 0);
    step(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    step(1, 64'h22, 0, 64'd0, 1, 0, 0, 0);
    step(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      drive_and_check(0, 64'd0, 0, 64'd0, 1, 1, 1, 0);
      check_eq("bp_ready_low", cache_resp_ready_out, 0);
      check_eq("bp_resp1_valid", resp1_valid_out, 1);
      advance();
    end
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 1, 1, 1);
    check_eq("route_first_r1", resp1_valid_out, 1);
    check_eq("route_first_rdy", cache_resp_ready_out, 1);
    advance();
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 1, 1, 0);
    check_eq("route_second_r0", resp0_valid_out, 1);
    check_eq("route_second_r1", resp1_valid_out, 0);
    advance();

    // Response with empty FIFO sets the sticky error
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 1, 1, 1);
    check_eq("err_no_resp", resp0_valid_out | resp1_valid_out, 0);
    advance();
    for (int c = 0; c < 3; c++) begin
      drive_and_check(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
      check_eq("err_sticky", err_out, 1);
      advance();
    end

    // Reset with three requests outstanding
    step(1, 64'h31, 0, 64'd0, 1, 0, 0, 0);
    step(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    step(0, 64'd0, 1, 64'h32, 1, 0, 0, 0);
    step(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    step(1, 64'h33, 0, 64'd0, 1, 0, 0, 0);
    drive_and_check(0, 64'd0, 0, 64'd0, 1, 0, 0, 0);
    check_eq("pre_rst_occ", outstanding_out, 3);
    advance();
    do_reset();

    // Randomized traffic; requesters hold valid and data until granted
    p0 = 1'b0; p1 = 1'b0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!p0 && $urandom_range(0, 2) != 0) begin p0 = 1'b1; pd0 = {$urandom, $urandom}; end
      if (!p1 && $urandom_range(0, 2) != 0) begin p1 = 1'b1; pd1 = {$urandom, $urandom}; end
      rv = (mq.size() > 0) && ($urandom_range(0, 2) == 0);
      drive_and_check(p0, pd0, p1, pd1, $urandom_range(0, 3) != 0, rv,
                      $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (e_grant && e_side == 0) p0 = 1'b0;
      if (e_grant && e_side == 1) p1 = 1'b0;
      advance();
      if (c == 1500) begin
        do_reset();
        p0 = 1'b0; p1 = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
